// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage_if
//  Description : Bundle of ID-side inputs and EX-side registered outputs of
//                the ID/EX operand stage.
//                slave  : the operand stage (consumes ID/EX/MEM signals,
//                         drives Op1_EX/Op2_EX/Valid_EX/Stall_ID)
//                master : the surrounding pipeline (the opposite direction)
//  Ports       : RN1/RN2, RD1/RD2, Reg_Forwarding1/2, Valid_ID, RN1_EX,
//                MemRead_EX, ALU_Result_EX, R0_Result_EX, Mem_Data_MEM, Flush
//                -> stage; Op1_EX/Op2_EX, Valid_EX, Stall_ID <- stage
//  Revision    : 1.0  initial release
// ============================================================================
interface id_ex_operand_stage_if #(
    parameter int DATA_WIDTH                = 16,
    parameter int REGISTER_NUMBER_BIT_WIDTH = 4
);
    logic [REGISTER_NUMBER_BIT_WIDTH-1:0] RN1;
    logic [REGISTER_NUMBER_BIT_WIDTH-1:0] RN2;
    logic [DATA_WIDTH-1:0]                RD1;
    logic [DATA_WIDTH-1:0]                RD2;
    logic [1:0]                           Reg_Forwarding1;
    logic [1:0]                           Reg_Forwarding2;
    logic                                 Valid_ID;
    logic [REGISTER_NUMBER_BIT_WIDTH-1:0] RN1_EX;
    logic                                 MemRead_EX;
    logic [DATA_WIDTH-1:0]                ALU_Result_EX;
    logic [DATA_WIDTH-1:0]                R0_Result_EX;
    logic [DATA_WIDTH-1:0]                Mem_Data_MEM;
    logic                                 Flush;
    logic [DATA_WIDTH-1:0]                Op1_EX;
    logic [DATA_WIDTH-1:0]                Op2_EX;
    logic                                 Valid_EX;
    logic                                 Stall_ID;

    modport slave (
        input  RN1, RN2, RD1, RD2, Reg_Forwarding1, Reg_Forwarding2,
        input  Valid_ID, RN1_EX, MemRead_EX, ALU_Result_EX, R0_Result_EX,
        input  Mem_Data_MEM, Flush,
        output Op1_EX, Op2_EX, Valid_EX, Stall_ID
    );

    modport master (
        output RN1, RN2, RD1, RD2, Reg_Forwarding1, Reg_Forwarding2,
        output Valid_ID, RN1_EX, MemRead_EX, ALU_Result_EX, R0_Result_EX,
        output Mem_Data_MEM, Flush,
        input  Op1_EX, Op2_EX, Valid_EX, Stall_ID
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : ID/EX pipeline register with operand forwarding mux and
//                load-use hazard handling. A load in EX whose destination
//                matches an ID source stalls ID for one cycle, inserts one
//                bubble, and then feeds Mem_Data_MEM to the matching
//                operand(s). Flush squashes the ID instruction in any state.
//  Ports       : clk, rst (synchronous, active high)
//                bus  : id_ex_operand_stage_if.slave (see interface header)
//  Config      : FWD_R0_EN defined   -> select 10 forwards R0_Result_EX
//                FWD_R0_EN undefined -> select 10 behaves as 00 (RDn)
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int DATA_WIDTH                = 16,
    parameter int REGISTER_NUMBER_BIT_WIDTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    id_ex_operand_stage_if.slave    bus
);

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_LU_STALL = 1'b1;

    logic [0:0]                           r_state;
    logic [0:0]                           w_state_nxt;
    logic                                 r_match1;
    logic                                 r_match2;
    logic [REGISTER_NUMBER_BIT_WIDTH-1:0] r_load_dest;
    logic [DATA_WIDTH-1:0]                r_op1;
    logic [DATA_WIDTH-1:0]                r_op2;
    logic                                 r_valid;

    logic                                 w_hazard;
    logic                                 w_stall;
    logic                                 w_capture;
    logic                                 w_nxt_valid;
    logic [DATA_WIDTH-1:0]                w_nxt_op1;
    logic [DATA_WIDTH-1:0]                w_nxt_op2;
    logic [1:0]                           w_sel1;
    logic [1:0]                           w_sel2;
    logic [DATA_WIDTH-1:0]                w_fwd1;
    logic [DATA_WIDTH-1:0]                w_fwd2;
    logic                                 w_match1;
    logic                                 w_match2;

    // Forwarding mux: 01 -> EX ALU result, 10 -> EX R0 result, else regfile.
    function automatic logic [DATA_WIDTH-1:0] f_select(
        input logic [1:0]            sel,
        input logic [DATA_WIDTH-1:0] rd,
        input logic [DATA_WIDTH-1:0] alu,
        input logic [DATA_WIDTH-1:0] r0
    );
        logic [DATA_WIDTH-1:0] v;
        case (sel)
            2'b01:   v = alu;
            2'b10:   v = r0;
            default: v = rd;
        endcase
        return v;
    endfunction

`ifdef FWD_R0_EN
    assign w_sel1 = bus.Reg_Forwarding1;
    assign w_sel2 = bus.Reg_Forwarding2;
`else
    // Without R0 forwarding, code 10 falls back to the register file value.
    assign w_sel1 = (bus.Reg_Forwarding1 == 2'b10) ? 2'b00 : bus.Reg_Forwarding1;
    assign w_sel2 = (bus.Reg_Forwarding2 == 2'b10) ? 2'b00 : bus.Reg_Forwarding2;
`endif

    assign w_fwd1 = f_select(w_sel1, bus.RD1, bus.ALU_Result_EX, bus.R0_Result_EX);
    assign w_fwd2 = f_select(w_sel2, bus.RD2, bus.ALU_Result_EX, bus.R0_Result_EX);

    assign w_match1 = (bus.RN1 == bus.RN1_EX);
    assign w_match2 = (bus.RN2 == bus.RN1_EX);

    // Gating on IDLE prevents a second stall for the instruction that was
    // just held, so a load-use always costs exactly one bubble.
    assign w_hazard = bus.Valid_ID & bus.MemRead_EX & (r_state == c_ST_IDLE)
                    & (w_match1 | w_match2);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        if (!bus.Flush && w_hazard) begin
            w_state_nxt = c_ST_LU_STALL;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and next pipeline-register values
    // ------------------------------------------------------------------
    always_comb begin
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        w_nxt_valid = 1'b0;
        w_nxt_op1   = '0;
        w_nxt_op2   = '0;
        if (bus.Flush) begin
            // Bubble: everything stays at its zero default.
        end else if (w_hazard) begin
            w_stall   = 1'b1;
            w_capture = 1'b1;
        end else if (r_state == c_ST_LU_STALL) begin
            w_nxt_valid = bus.Valid_ID;
            if (bus.Valid_ID) begin
                // Loaded data outranks whatever the forwarding unit chose.
                w_nxt_op1 = r_match1 ? bus.Mem_Data_MEM : w_fwd1;
                w_nxt_op2 = r_match2 ? bus.Mem_Data_MEM : w_fwd2;
            end
        end else begin
            w_nxt_valid = bus.Valid_ID;
            if (bus.Valid_ID) begin
                w_nxt_op1 = w_fwd1;
                w_nxt_op2 = w_fwd2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline and hazard-tracking registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op1       <= '0;
            r_op2       <= '0;
            r_valid     <= 1'b0;
            r_match1    <= 1'b0;
            r_match2    <= 1'b0;
            r_load_dest <= '0;
        end else begin
            r_op1   <= w_nxt_op1;
            r_op2   <= w_nxt_op2;
            r_valid <= w_nxt_valid;
            if (w_capture) begin
                r_match1    <= w_match1;
                r_match2    <= w_match2;
                r_load_dest <= bus.RN1_EX;
            end else begin
                r_match1 <= 1'b0;
                r_match2 <= 1'b0;
            end
        end
    end

    // The captured load destination is kept for observability only; the
    // per-operand match bits already carry the comparison result.
    logic w_unused_sink;
    assign w_unused_sink = ^r_load_dest;

    assign bus.Op1_EX   = r_op1;
    assign bus.Op2_EX   = r_op2;
    assign bus.Valid_EX = r_valid;
    assign bus.Stall_ID = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Self-checking bench for id_ex_operand_stage: table of
//                single-cycle vectors plus directed multi-cycle sequences
//                (load-use, double match, flush, reset mid-stall).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_operand_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_ex_operand_stage_if #(.DATA_WIDTH(16), .REGISTER_NUMBER_BIT_WIDTH(4)) bus ();

    id_ex_operand_stage #(.DATA_WIDTH(16), .REGISTER_NUMBER_BIT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FWD_R0_EN
    localparam logic [15:0] c_R0_EXP1 = 16'h5555;
    localparam logic [15:0] c_R0_EXP2 = 16'h5555;
`else
    localparam logic [15:0] c_R0_EXP1 = 16'h1111;
    localparam logic [15:0] c_R0_EXP2 = 16'h2222;
`endif

    typedef struct {
        logic [3:0]  rn1;
        logic [3:0]  rn2;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        valid;
        logic [3:0]  rn1_ex;
        logic        memread;
        logic        flush;
        logic        exp_stall;
        logic [15:0] exp_op1;
        logic [15:0] exp_op2;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.RN1 = 4'd1;            bus.RN2 = 4'd2;
        bus.RD1 = 16'h1111;        bus.RD2 = 16'h2222;
        bus.Reg_Forwarding1 = 2'b00; bus.Reg_Forwarding2 = 2'b00;
        bus.Valid_ID = 1'b1;       bus.RN1_EX = 4'd0;
        bus.MemRead_EX = 1'b0;     bus.ALU_Result_EX = 16'hAAAA;
        bus.R0_Result_EX = 16'h5555; bus.Mem_Data_MEM = 16'hBEEF;
        bus.Flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //           rn1 rn2 f1     f2     v  rnex mr flush stall op1          op2          valid
        vecs[0] = '{4'd1, 4'd2, 2'b00, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1};
        vecs[1] = '{4'd1, 4'd2, 2'b01, 2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h2222, 1'b1};
        vecs[2] = '{4'd1, 4'd2, 2'b10, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, c_R0_EXP1, 16'hAAAA, 1'b1};
        vecs[3] = '{4'd1, 4'd2, 2'b11, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1111, c_R0_EXP2, 1'b1};
        vecs[4] = '{4'd1, 4'd2, 2'b01, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{4'd1, 4'd2, 2'b01, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[6] = '{4'd1, 4'd2, 2'b00, 2'b00, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1};
        vecs[7] = '{4'd3, 4'd5, 2'b00, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[8] = '{4'd3, 4'd5, 2'b01, 2'b00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h2222, 1'b1};

        // Reset
        idle_inputs();
        bus.Valid_ID = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("reset_op1",   bus.Op1_EX, 16'h0000);
        check("reset_op2",   bus.Op2_EX, 16'h0000);
        check("reset_valid", {15'd0, bus.Valid_EX}, 16'd0);
        check("reset_stall", {15'd0, bus.Stall_ID}, 16'd0);
        rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            bus.RN1 = vecs[i].rn1;             bus.RN2 = vecs[i].rn2;
            bus.Reg_Forwarding1 = vecs[i].f1;  bus.Reg_Forwarding2 = vecs[i].f2;
            bus.Valid_ID = vecs[i].valid;      bus.RN1_EX = vecs[i].rn1_ex;
            bus.MemRead_EX = vecs[i].memread;  bus.Flush = vecs[i].flush;
            #1;
            check($sformatf("vec%0d_stall", i), {15'd0, bus.Stall_ID}, {15'd0, vecs[i].exp_stall});
            step();
            check($sformatf("vec%0d_op1", i), bus.Op1_EX, vecs[i].exp_op1);
            check($sformatf("vec%0d_op2", i), bus.Op2_EX, vecs[i].exp_op2);
            check($sformatf("vec%0d_valid", i), {15'd0, bus.Valid_EX}, {15'd0, vecs[i].exp_valid});
        end

        // Load-use on operand 1; load stays flagged in EX during the stall
        // cycle to show the hazard check does not fire twice.
        idle_inputs();
        bus.MemRead_EX = 1'b1; bus.RN1_EX = 4'd3; bus.RN1 = 4'd3; bus.RN2 = 4'd5;
        bus.RD2 = 16'h0007;
        #1;
        check("lu_stall_c0", {15'd0, bus.Stall_ID}, 16'd1);
        step();
        check("lu_bubble_valid", {15'd0, bus.Valid_EX}, 16'd0);
        check("lu_bubble_op1", bus.Op1_EX, 16'h0000);
        bus.Mem_Data_MEM = 16'hBEEF;
        #1;
        check("lu_stall_c1", {15'd0, bus.Stall_ID}, 16'd0);
        step();
        check("lu_op1", bus.Op1_EX, 16'hBEEF);
        check("lu_op2", bus.Op2_EX, 16'h0007);
        check("lu_valid", {15'd0, bus.Valid_EX}, 16'd1);

        // Double match, with forwarding codes that must be overridden
        idle_inputs();
        bus.MemRead_EX = 1'b1; bus.RN1_EX = 4'd2; bus.RN1 = 4'd2; bus.RN2 = 4'd2;
        bus.Reg_Forwarding1 = 2'b01; bus.Reg_Forwarding2 = 2'b01;
        #1;
        check("dm_stall", {15'd0, bus.Stall_ID}, 16'd1);
        step();
        bus.MemRead_EX = 1'b0; bus.Mem_Data_MEM = 16'h1234;
        step();
        check("dm_op1", bus.Op1_EX, 16'h1234);
        check("dm_op2", bus.Op2_EX, 16'h1234);
        check("dm_valid", {15'd0, bus.Valid_EX}, 16'd1);

        // Reset asserted while in LU_STALL
        idle_inputs();
        bus.MemRead_EX = 1'b1; bus.RN1_EX = 4'd3; bus.RN1 = 4'd3;
        step();
        bus.MemRead_EX = 1'b0; bus.Mem_Data_MEM = 16'h1234;
        rst = 1'b1;
        step();
        check("rst_lu_op1", bus.Op1_EX, 16'h0000);
        check("rst_lu_op2", bus.Op2_EX, 16'h0000);
        check("rst_lu_valid", {15'd0, bus.Valid_EX}, 16'd0);
        check("rst_lu_stall", {15'd0, bus.Stall_ID}, 16'd0);
        rst = 1'b0;
        idle_inputs();
        step();
        check("post_rst_op1", bus.Op1_EX, 16'h1111);
        check("post_rst_op2", bus.Op2_EX, 16'h2222);
        check("post_rst_valid", {15'd0, bus.Valid_EX}, 16'd1);

        // Flush while in LU_STALL: bubble, then back in IDLE so a fresh
        // hazard stalls again.
        idle_inputs();
        bus.MemRead_EX = 1'b1; bus.RN1_EX = 4'd3; bus.RN1 = 4'd3;
        step();
        bus.Flush = 1'b1;
        #1;
        check("fl_lu_stall", {15'd0, bus.Stall_ID}, 16'd0);
        step();
        check("fl_lu_valid", {15'd0, bus.Valid_EX}, 16'd0);
        check("fl_lu_op1", bus.Op1_EX, 16'h0000);
        bus.Flush = 1'b0;
        #1;
        check("fl_then_stall", {15'd0, bus.Stall_ID}, 16'd1);
        step();
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
